// File: rtl/instr_pkg.sv
// Shared RISC-V instruction/operand types used across the pipeline.
// The register file takes its address/data types and register count from here.
package instr;

    // Number of architectural integer registers (x0..x31).
    localparam int NUM_RV_REGS = 32;

    // Register specifier as carried by decode, issue and retire.
    typedef logic [4:0]  t_rv_reg_addr;

    // Integer register value.
    typedef logic [31:0] t_rv_reg_data;

endpackage : instr

// File: rtl/regfile_sb.sv
// Pending-write scoreboard for the integer register file.
// One bit per architectural register marks an issued-but-not-retired writer.
// A same-cycle retire write to a source clears its hazard through the
// register file bypass, so it does not contribute to the stall.
module regfile_sb
    import instr::*;
#(
    parameter int NUM_REGS = NUM_RV_REGS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sbset_rd0,
    input  t_rv_reg_addr        sbaddr_rd0,
    input  logic                wren_rb0,
    input  t_rv_reg_addr        wraddr_rb0,
    input  logic                rden0_rd0,
    input  t_rv_reg_addr        rdaddr0_rd0,
    input  logic                rden1_rd0,
    input  t_rv_reg_addr        rdaddr1_rd0,
    output logic                stall_rd0,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_v;
    logic [NUM_REGS-1:0] clr_v;

    // x0 never has a pending writer: its bit is tied low.
    assign set_v[0]     = 1'b0;
    assign clr_v[0]     = 1'b0;
    assign pending_d[0] = 1'b0;

    // Per-register set/clear decode. Set wins over clear because the
    // issuing instruction is younger than the one retiring.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
            assign set_v[gi]     = sbset_rd0 && (sbaddr_rd0 == t_rv_reg_addr'(gi));
            assign clr_v[gi]     = wren_rb0  && (wraddr_rb0 == t_rv_reg_addr'(gi));
            assign pending_d[gi] = set_v[gi] | (pending_q[gi] & ~clr_v[gi]);
        end
    endgenerate

    // Scoreboard state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    logic hazard0;
    logic hazard1;

    // RAW hazard per read port, masked by a same-cycle retire to that source.
    always_comb begin
        hazard0   = rden0_rd0 && pending_q[rdaddr0_rd0]
                    && !(wren_rb0 && (wraddr_rb0 == rdaddr0_rd0));
        hazard1   = rden1_rd0 && pending_q[rdaddr1_rd0]
                    && !(wren_rb0 && (wraddr_rb0 == rdaddr1_rd0));
        stall_rd0 = hazard0 | hazard1;
    end

    assign pending = pending_q;

`ifdef ASSERT
    // Protocol checks on the issue/retire handshake of the in-order core.
    always @(posedge clk) begin
        if (reset_n) begin
            if (wren_rb0 && (wraddr_rb0 != '0)) begin
                assert (pending_q[wraddr_rb0])
                    else $error("regfile_sb: retire to x%0d with no pending writer", wraddr_rb0);
            end
            if (sbset_rd0 && (sbaddr_rd0 != '0)) begin
                assert (!pending_q[sbaddr_rd0])
                    else $error("regfile_sb: second outstanding writer to x%0d", sbaddr_rd0);
            end
            assert (!(sbset_rd0 && stall_rd0))
                else $error("regfile_sb: issue while stalled");
        end
    end
`endif

endmodule : regfile_sb

// File: rtl/regfile.sv
// Architectural integer register file with two registered read ports,
// one retire write port with same-cycle bypass, and a pending-write
// scoreboard driving the issue-stage RAW stall.
// XLEN is expected to match the width of t_rv_reg_data.
module regfile
    import instr::*;
#(
    parameter int NUM_REGS = NUM_RV_REGS,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rden0_rd0,
    input  logic                rden1_rd0,
    input  t_rv_reg_addr        rdaddr0_rd0,
    input  t_rv_reg_addr        rdaddr1_rd0,
    output t_rv_reg_data        rddata0_rd1,
    output t_rv_reg_data        rddata1_rd1,
    input  logic                sbset_rd0,
    input  t_rv_reg_addr        sbaddr_rd0,
    output logic                stall_rd0,
    input  logic                wren_rb0,
    input  t_rv_reg_addr        wraddr_rb0,
    input  t_rv_reg_data        wrdata_rb0,
    output logic [NUM_REGS-1:0] pending
);

    // Storage: x0 is kept as a constant-zero entry so reads index uniformly.
    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;

    assign wr_sel[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_wsel
            assign wr_sel[gi] = wren_rb0 && (wraddr_rb0 == t_rv_reg_addr'(gi));
        end
    endgenerate

    // Architectural register write; writes to x0 are dropped by wr_sel[0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= wrdata_rb0;
                end
            end
        end
    end

    t_rv_reg_data rddata0_q;
    t_rv_reg_data rddata0_d;
    t_rv_reg_data rddata1_q;
    t_rv_reg_data rddata1_d;
    logic         byp0;
    logic         byp1;

    // Read-port next data: x0 reads zero, a same-cycle retire to the source
    // is forwarded, otherwise storage; a disabled port holds its last value.
    always_comb begin
        byp0      = wren_rb0 && (wraddr_rb0 == rdaddr0_rd0);
        byp1      = wren_rb0 && (wraddr_rb0 == rdaddr1_rd0);
        rddata0_d = rddata0_q;
        rddata1_d = rddata1_q;
        if (rden0_rd0) begin
            if (rdaddr0_rd0 == '0) begin
                rddata0_d = '0;
            end else if (byp0) begin
                rddata0_d = wrdata_rb0;
            end else begin
                rddata0_d = regs_q[rdaddr0_rd0];
            end
        end
        if (rden1_rd0) begin
            if (rdaddr1_rd0 == '0) begin
                rddata1_d = '0;
            end else if (byp1) begin
                rddata1_d = wrdata_rb0;
            end else begin
                rddata1_d = regs_q[rdaddr1_rd0];
            end
        end
    end

    // Read-port output registers (rd0 request -> rd1 data).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rddata0_q <= '0;
            rddata1_q <= '0;
        end else begin
            rddata0_q <= rddata0_d;
            rddata1_q <= rddata1_d;
        end
    end

    assign rddata0_rd1 = rddata0_q;
    assign rddata1_rd1 = rddata1_q;

    regfile_sb #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .sbset_rd0   (sbset_rd0),
        .sbaddr_rd0  (sbaddr_rd0),
        .wren_rb0    (wren_rb0),
        .wraddr_rb0  (wraddr_rb0),
        .rden0_rd0   (rden0_rd0),
        .rdaddr0_rd0 (rdaddr0_rd0),
        .rden1_rd0   (rden1_rd0),
        .rdaddr1_rd0 (rdaddr1_rd0),
        .stall_rd0   (stall_rd0),
        .pending     (pending)
    );

`ifdef SIMULATION
    // Trace every architectural write for debug.
    always @(posedge clk) begin
        if (reset_n && wren_rb0 && (wraddr_rb0 != '0)) begin
            $display("INFO regfile: x%0d <= 0x%08h", wraddr_rb0, wrdata_rb0);
        end
    end
`endif

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, a mid-stream
// asynchronous reset sequence, and randomized issue/retire/read traffic
// compared against an array-based model of the architectural state.
module tb_regfile;
    import instr::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         rden0_rd0, rden1_rd0;
    t_rv_reg_addr rdaddr0_rd0, rdaddr1_rd0;
    t_rv_reg_data rddata0_rd1, rddata1_rd1;
    logic         sbset_rd0;
    t_rv_reg_addr sbaddr_rd0;
    logic         stall_rd0;
    logic         wren_rb0;
    t_rv_reg_addr wraddr_rb0;
    t_rv_reg_data wrdata_rb0;
    logic [31:0]  pending;

    always #5 clk = ~clk;

    regfile #(.NUM_REGS(32), .XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rden0_rd0   (rden0_rd0),
        .rden1_rd0   (rden1_rd0),
        .rdaddr0_rd0 (rdaddr0_rd0),
        .rdaddr1_rd0 (rdaddr1_rd0),
        .rddata0_rd1 (rddata0_rd1),
        .rddata1_rd1 (rddata1_rd1),
        .sbset_rd0   (sbset_rd0),
        .sbaddr_rd0  (sbaddr_rd0),
        .stall_rd0   (stall_rd0),
        .wren_rb0    (wren_rb0),
        .wraddr_rb0  (wraddr_rb0),
        .wrdata_rb0  (wrdata_rb0),
        .pending     (pending)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rden0_rd0 = 0; rden1_rd0 = 0; rdaddr0_rd0 = 0; rdaddr1_rd0 = 0;
        sbset_rd0 = 0; sbaddr_rd0 = 0; wren_rb0 = 0; wraddr_rb0 = 0; wrdata_rb0 = 0;
    endtask

    // Reference model: architectural values, outstanding writers, read outputs.
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_rd0, m_rd1;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pend = 0; m_rd0 = 0; m_rd1 = 0;
    endtask

    function automatic logic [31:0] model_value(input logic [4:0] a);
        if (a == 0) return 0;
        if (wren_rb0 && wraddr_rb0 == a) return wrdata_rb0;
        return m_regs[a];
    endfunction

    // A source stalls when it has an outstanding writer that is not retiring now.
    function automatic logic model_stall();
        logic s0, s1;
        s0 = rden0_rd0 && m_pend[rdaddr0_rd0] && !(wren_rb0 && wraddr_rb0 == rdaddr0_rd0);
        s1 = rden1_rd0 && m_pend[rdaddr1_rd0] && !(wren_rb0 && wraddr_rb0 == rdaddr1_rd0);
        return s0 || s1;
    endfunction

    task automatic model_clock();
        if (rden0_rd0) m_rd0 = model_value(rdaddr0_rd0);
        if (rden1_rd0) m_rd1 = model_value(rdaddr1_rd0);
        if (wren_rb0 && wraddr_rb0 != 0) begin
            m_regs[wraddr_rb0] = wrdata_rb0;
            m_pend[wraddr_rb0] = 1'b0;
        end
        if (sbset_rd0 && sbaddr_rd0 != 0) m_pend[sbaddr_rd0] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        model_reset();
    endtask

    // Asynchronous reset mid-cycle with a read in flight.
    task automatic mid_reset(input logic [4:0] ra);
        @(negedge clk);
        idle_inputs();
        rden0_rd0 = 1; rdaddr0_rd0 = ra; rden1_rd0 = 1; rdaddr1_rd0 = ra;
        @(posedge clk);
        #2;
        reset_n = 0;
        #1;
        check("async_rst_rd0", rddata0_rd1, 32'h0);
        check("async_rst_rd1", rddata1_rd1, 32'h0);
        check("async_rst_pending", pending, 32'h0);
        check("async_rst_stall", {31'b0, stall_rd0}, 32'h0);
        @(negedge clk);
        reset_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        check("post_rst_read", rddata0_rd1, 32'h0);
        $display("mid-stream reset: read x%0d after reset rd0=%08h pending=%08h", ra, rddata0_rd1, pending);
    endtask

    typedef struct {
        logic        wren;  logic [4:0] wa;  logic [31:0] wd;
        logic        sbset; logic [4:0] sa;
        logic        rden0; logic [4:0] ra0;
        logic        rden1; logic [4:0] ra1;
        logic        stall; logic [31:0] rd0; logic [31:0] rd1; logic [31:0] pend;
    } vec_t;

    vec_t tbl [12];

    task automatic run_random(input int cycles);
        int q[$];
        int pick;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            idle_inputs();
            rden0_rd0   = ($urandom % 4) != 0;
            rden1_rd0   = ($urandom % 4) != 0;
            rdaddr0_rd0 = 5'($urandom % 32);
            rdaddr1_rd0 = ($urandom % 4 == 0) ? rdaddr0_rd0 : 5'($urandom % 32);
            q.delete();
            for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
            if (q.size() != 0 && ($urandom % 2) == 1) begin
                pick       = q[$urandom % q.size()];
                wren_rb0   = 1;
                wraddr_rb0 = 5'(pick);
                wrdata_rb0 = $urandom;
            end else if ($urandom % 16 == 0) begin
                wren_rb0   = 1;
                wraddr_rb0 = 0;
                wrdata_rb0 = $urandom;
            end
            if (!model_stall() && ($urandom % 2) == 1) begin
                q.delete();
                for (int i = 1; i < 32; i++) if (!m_pend[i]) q.push_back(i);
                if ($urandom % 16 == 0) begin
                    sbset_rd0 = 1; sbaddr_rd0 = 0;
                end else if (q.size() != 0) begin
                    sbset_rd0  = 1;
                    sbaddr_rd0 = 5'(q[$urandom % q.size()]);
                end
            end
            #1;
            check("rnd_stall", {31'b0, stall_rd0}, {31'b0, model_stall()});
            model_clock();
            @(posedge clk);
            #1;
            check("rnd_rd0", rddata0_rd1, m_rd0);
            check("rnd_rd1", rddata1_rd1, m_rd1);
            check("rnd_pending", pending, m_pend);
            if (c % 1000 == 999)
                $display("random cycle %0d: pending=%08h rd0=%08h rd1=%08h", c + 1, pending, rddata0_rd1, rddata1_rd1);
        end
    endtask

    initial begin
        //            wren wa  wd            sbset sa  rden0 ra0 rden1 ra1 stall rd0           rd1           pend
        tbl[0]  = '{1'b0, 0,  32'h0,        1'b0, 0,  1'b1, 5,  1'b1, 0,  1'b0, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b1, 3,  32'hDEADBEEF, 1'b0, 0,  1'b0, 0,  1'b0, 0,  1'b0, 32'h0,        32'h0,        32'h0};
        tbl[2]  = '{1'b0, 0,  32'h0,        1'b0, 0,  1'b1, 3,  1'b0, 0,  1'b0, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[3]  = '{1'b1, 0,  32'h1234,     1'b0, 0,  1'b1, 0,  1'b1, 0,  1'b0, 32'h0,        32'h0,        32'h0};
        tbl[4]  = '{1'b1, 7,  32'hA5A5A5A5, 1'b0, 0,  1'b1, 7,  1'b1, 7,  1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
        tbl[5]  = '{1'b0, 0,  32'h0,        1'b1, 9,  1'b1, 3,  1'b1, 7,  1'b0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h200};
        tbl[6]  = '{1'b0, 0,  32'h0,        1'b0, 0,  1'b1, 9,  1'b0, 0,  1'b1, 32'h0,        32'hA5A5A5A5, 32'h200};
        tbl[7]  = '{1'b1, 9,  32'h42,       1'b0, 0,  1'b1, 9,  1'b0, 0,  1'b0, 32'h42,       32'hA5A5A5A5, 32'h0};
        tbl[8]  = '{1'b1, 4,  32'h11,       1'b1, 4,  1'b0, 0,  1'b0, 0,  1'b0, 32'h42,       32'hA5A5A5A5, 32'h10};
        tbl[9]  = '{1'b0, 0,  32'h0,        1'b0, 0,  1'b0, 0,  1'b1, 4,  1'b1, 32'h42,       32'h11,       32'h10};
        tbl[10] = '{1'b1, 4,  32'h22,       1'b0, 0,  1'b1, 4,  1'b1, 4,  1'b0, 32'h22,       32'h22,       32'h0};
        tbl[11] = '{1'b0, 0,  32'h0,        1'b1, 0,  1'b1, 0,  1'b1, 3,  1'b0, 32'h0,        32'hDEADBEEF, 32'h0};

        idle_inputs();
        reset_n = 0;
        #12;
        check("reset_rd0", rddata0_rd1, 32'h0);
        check("reset_rd1", rddata1_rd1, 32'h0);
        check("reset_pending", pending, 32'h0);
        check("reset_stall", {31'b0, stall_rd0}, 32'h0);
        @(negedge clk);
        reset_n = 1;
        model_reset();

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            wren_rb0 = tbl[v].wren;   wraddr_rb0 = tbl[v].wa;   wrdata_rb0 = tbl[v].wd;
            sbset_rd0 = tbl[v].sbset; sbaddr_rd0 = tbl[v].sa;
            rden0_rd0 = tbl[v].rden0; rdaddr0_rd0 = tbl[v].ra0;
            rden1_rd0 = tbl[v].rden1; rdaddr1_rd0 = tbl[v].ra1;
            #1;
            check($sformatf("vec%0d_stall", v), {31'b0, stall_rd0}, {31'b0, tbl[v].stall});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd0", v), rddata0_rd1, tbl[v].rd0);
            check($sformatf("vec%0d_rd1", v), rddata1_rd1, tbl[v].rd1);
            check($sformatf("vec%0d_pending", v), pending, tbl[v].pend);
            $display("vec %0d: wr=%0d x%0d=%08h sbset=%0d x%0d rd0=%08h rd1=%08h pend=%08h",
                     v, tbl[v].wren, tbl[v].wa, tbl[v].wd, tbl[v].sbset, tbl[v].sa,
                     rddata0_rd1, rddata1_rd1, pending);
        end

        // Build up state, then reset asynchronously mid-cycle.
        @(negedge clk);
        idle_inputs();
        wren_rb0 = 1; wraddr_rb0 = 12; wrdata_rb0 = 32'hCAFEF00D;
        sbset_rd0 = 1; sbaddr_rd0 = 13;
        @(negedge clk);
        idle_inputs();
        rden0_rd0 = 1; rdaddr0_rd0 = 12; rden1_rd0 = 1; rdaddr1_rd0 = 12;
        @(posedge clk);
        #1;
        check("pre_rst_rd0", rddata0_rd1, 32'hCAFEF00D);
        check("pre_rst_pending", pending, 32'h2000);
        mid_reset(12);

        do_reset();
        run_random(5000);
        mid_reset(5'($urandom_range(1, 31)));
        run_random(5000);

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile
